// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and stage-1 payload type for the Calvera
// pipelined ALU (alu_pipe). Extended opcodes are only decoded when the
// design is built with CALVERA_ALU_ZBB_EN.
package alu_pkg;

   localparam int ALU_OPC_W = 5;

   // Default configuration widths used by the payload typedef below.
   localparam int ALU_XLEN   = 32;
   localparam int ALU_ROB_W  = 5;
   localparam int ALU_DEST_W = 6;

   // Full 5-bit opcodes, base group (opc[4] = 0).
   localparam logic [ALU_OPC_W-1:0] OPC_ADD  = 5'b00000;
   localparam logic [ALU_OPC_W-1:0] OPC_SUB  = 5'b01000;
   localparam logic [ALU_OPC_W-1:0] OPC_SLL  = 5'b00001;
   localparam logic [ALU_OPC_W-1:0] OPC_SLT  = 5'b00010;
   localparam logic [ALU_OPC_W-1:0] OPC_SLTU = 5'b00011;
   localparam logic [ALU_OPC_W-1:0] OPC_XOR  = 5'b00100;
   localparam logic [ALU_OPC_W-1:0] OPC_SRL  = 5'b00101;
   localparam logic [ALU_OPC_W-1:0] OPC_SRA  = 5'b01101;
   localparam logic [ALU_OPC_W-1:0] OPC_OR   = 5'b00110;
   localparam logic [ALU_OPC_W-1:0] OPC_AND  = 5'b00111;

   // Full 5-bit opcodes, extended group (opc[4] = 1).
   localparam logic [ALU_OPC_W-1:0] OPC_MIN  = 5'b10000;
   localparam logic [ALU_OPC_W-1:0] OPC_MAX  = 5'b10001;
   localparam logic [ALU_OPC_W-1:0] OPC_MINU = 5'b10010;
   localparam logic [ALU_OPC_W-1:0] OPC_MAXU = 5'b10011;
   localparam logic [ALU_OPC_W-1:0] OPC_ANDN = 5'b10100;
   localparam logic [ALU_OPC_W-1:0] OPC_ORN  = 5'b10101;
   localparam logic [ALU_OPC_W-1:0] OPC_XNOR = 5'b10110;
   localparam logic [ALU_OPC_W-1:0] OPC_CLZ  = 5'b10111;

   // Function field opc[2:0]; opc[3] selects sub / arithmetic shift in the
   // base group and is ignored in the extended group.
   localparam logic [2:0] FN_ADDSUB = 3'b000;
   localparam logic [2:0] FN_SLL    = 3'b001;
   localparam logic [2:0] FN_SLT    = 3'b010;
   localparam logic [2:0] FN_SLTU   = 3'b011;
   localparam logic [2:0] FN_XOR    = 3'b100;
   localparam logic [2:0] FN_SHR    = 3'b101;
   localparam logic [2:0] FN_OR     = 3'b110;
   localparam logic [2:0] FN_AND    = 3'b111;

   localparam logic [2:0] FN_MIN    = 3'b000;
   localparam logic [2:0] FN_MAX    = 3'b001;
   localparam logic [2:0] FN_MINU   = 3'b010;
   localparam logic [2:0] FN_MAXU   = 3'b011;
   localparam logic [2:0] FN_ANDN   = 3'b100;
   localparam logic [2:0] FN_ORN    = 3'b101;
   localparam logic [2:0] FN_XNOR   = 3'b110;
   localparam logic [2:0] FN_CLZ    = 3'b111;

   // Stage-1 payload for the default configuration.
   typedef struct packed {
      logic [ALU_OPC_W-1:0]  opc;
      logic [ALU_XLEN-1:0]   a;
      logic [ALU_XLEN-1:0]   b;
      logic [ALU_ROB_W-1:0]  rob_id;
      logic [ALU_DEST_W-1:0] dest;
   } s1_payload_t;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: sll/srl/sra from a single right-shifting barrel shifter.
// Left shifts reverse the operand on the way in and the result on the way out.
module alu_shifter #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]         data,
   input  logic [$clog2(XLEN)-1:0] shamt,
   input  logic                    left,
   input  logic                    arith,
   output logic [XLEN-1:0]         result
);

   localparam int LG = $clog2(XLEN);

   function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
      logic [XLEN-1:0] r;
      for (int i = 0; i < XLEN; i++) begin
         r[i] = v[XLEN-1-i];
      end
      return r;
   endfunction

   logic            fill;
   logic [XLEN-1:0] stage [0:LG];

   // Sign fill only for arithmetic right shifts.
   assign fill     = arith & ~left & data[XLEN-1];
   assign stage[0] = left ? bit_rev(data) : data;

   for (genvar i = 0; i < LG; i++) begin : g_stage
      assign stage[i+1] = shamt[i] ? {{(1 << i){fill}}, stage[i][XLEN-1:(1 << i)]}
                                   : stage[i];
   end

   assign result = left ? bit_rev(stage[LG]) : stage[LG];

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage back-pressurable integer ALU (issue -> writeback).
// Stage 1 registers the request, stage 2 computes into the output register.
// Build option: define CALVERA_ALU_ZBB_EN to decode the extended opcode group
// (min/max/minu/maxu/andn/orn/xnor/clz); otherwise those opcodes return 0.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ROB_W  = 5,
   parameter int DEST_W = 6
) (
   input  logic                 cpu_clock_i,
   input  logic                 cpu_reset_i,
   input  logic                 flush_i,
   input  logic [XLEN-1:0]      a_i,
   input  logic [XLEN-1:0]      b_i,
   input  logic [ALU_OPC_W-1:0] opc_i,
   input  logic [ROB_W-1:0]     rob_id_i,
   input  logic [DEST_W-1:0]    dest_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic [XLEN-1:0]      result_o,
   output logic [ROB_W-1:0]     rob_id_o,
   output logic [DEST_W-1:0]    dest_o,
   output logic                 valid_o,
   output logic                 wb_valid_o,
   input  logic                 wb_ready_i
);

   localparam int SH_W = $clog2(XLEN);

   typedef struct packed {
      logic [ALU_OPC_W-1:0] opc;
      logic [XLEN-1:0]      a;
      logic [XLEN-1:0]      b;
      logic [ROB_W-1:0]     rob_id;
      logic [DEST_W-1:0]    dest;
   } s1_t;

   logic               vld_p1;
   s1_t                pay_p1;
   logic               vld_p2;
   logic [XLEN-1:0]    res_p2;
   logic [ROB_W-1:0]   rob_p2;
   logic [DEST_W-1:0]  dest_p2;

   logic               stall;
   logic               accept;
   logic               move;

   logic [ALU_OPC_W-1:0] opc;
   logic [XLEN-1:0]      opa;
   logic [XLEN-1:0]      opb;
   logic signed [XLEN-1:0] opa_s;
   logic signed [XLEN-1:0] opb_s;
   logic [XLEN-1:0]      sum;
   logic [XLEN-1:0]      shift_res;
   logic                 lt_s;
   logic                 lt_u;
   logic [XLEN-1:0]      base_res;
   logic [XLEN-1:0]      ext_res;
   logic [XLEN-1:0]      alu_res;

   // Handshake: the output stalls only while it holds data nobody takes.
   assign stall   = vld_p2 & ~wb_ready_i;
   assign ready_o = ~vld_p1 | ~vld_p2 | wb_ready_i;
   assign accept  = valid_i & ready_o;
   assign move    = vld_p1 & ~stall;

   // ---- stage 1 / stage 2 valid bits ----
   // Valid tracking: reset beats flush, flush beats everything else.
   always_ff @(posedge cpu_clock_i) begin
      if (cpu_reset_i) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else if (flush_i) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         if (!stall) begin
            vld_p2 <= vld_p1;
         end
         if (accept) begin
            vld_p1 <= 1'b1;
         end else if (move) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   // Stage 1 payload capture; contents only matter while vld_p1 is set.
   always_ff @(posedge cpu_clock_i) begin
      if (accept) begin
         pay_p1 <= '{opc: opc_i, a: a_i, b: b_i, rob_id: rob_id_i, dest: dest_i};
      end
   end

   // ---- stage 2: compute from the stage 1 registers ----
   assign opc   = pay_p1.opc;
   assign opa   = pay_p1.a;
   assign opb   = pay_p1.b;
   assign opa_s = pay_p1.a;
   assign opb_s = pay_p1.b;

   assign sum  = opc[3] ? (opa - opb) : (opa + opb);
   assign lt_s = opa_s < opb_s;
   assign lt_u = opa < opb;

   alu_shifter #(.XLEN(XLEN)) u_shifter (
      .data   (opa),
      .shamt  (opb[SH_W-1:0]),
      .left   (opc[2:0] == FN_SLL),
      .arith  (opc[3]),
      .result (shift_res)
   );

   // Base opcode group result select.
   always_comb begin
      base_res = '0;
      case (opc[2:0])
         FN_ADDSUB: base_res = sum;
         FN_SLL:    base_res = shift_res;
         FN_SLT:    base_res = {{(XLEN-1){1'b0}}, lt_s};
         FN_SLTU:   base_res = {{(XLEN-1){1'b0}}, lt_u};
         FN_XOR:    base_res = opa ^ opb;
         FN_SHR:    base_res = shift_res;
         FN_OR:     base_res = opa | opb;
         FN_AND:    base_res = opa & opb;
         default:   base_res = '0;
      endcase
   end

`ifdef CALVERA_ALU_ZBB_EN
   // Leading-zero count; an all-zero operand yields XLEN.
   function automatic logic [XLEN-1:0] clz(input logic [XLEN-1:0] v);
      logic [XLEN-1:0] n;
      logic            found;
      n     = '0;
      found = 1'b0;
      for (int i = XLEN - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) begin
               found = 1'b1;
            end else begin
               n = n + 1'b1;
            end
         end
      end
      return n;
   endfunction

   // Extended opcode group result select.
   always_comb begin
      ext_res = '0;
      case (opc[2:0])
         FN_MIN:  ext_res = lt_s ? opa : opb;
         FN_MAX:  ext_res = lt_s ? opb : opa;
         FN_MINU: ext_res = lt_u ? opa : opb;
         FN_MAXU: ext_res = lt_u ? opb : opa;
         FN_ANDN: ext_res = opa & ~opb;
         FN_ORN:  ext_res = opa | ~opb;
         FN_XNOR: ext_res = ~(opa ^ opb);
         FN_CLZ:  ext_res = clz(opa);
         default: ext_res = '0;
      endcase
   end
`else
   assign ext_res = '0;
`endif

   assign alu_res = opc[4] ? ext_res : base_res;

   // ---- stage 2 output register ----
   // Output register loads whenever stage 1 advances; reset clears it.
   always_ff @(posedge cpu_clock_i) begin
      if (cpu_reset_i) begin
         res_p2  <= '0;
         rob_p2  <= '0;
         dest_p2 <= '0;
      end else if (move) begin
         res_p2  <= alu_res;
         rob_p2  <= pay_p1.rob_id;
         dest_p2 <= pay_p1.dest;
      end
   end

   assign result_o   = res_p2;
   assign rob_id_o   = rob_p2;
   assign dest_o     = dest_p2;
   assign valid_o    = vld_p2;
   assign wb_valid_o = vld_p2 & (dest_p2 != '0);

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: vector table, directed handshake/flush/reset sequences and a
// randomized run against a queue-based reference model of alu_pipe.
module tb_alu_pipe;

   localparam int XLEN   = 32;
   localparam int ROB_W  = 5;
   localparam int DEST_W = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic [XLEN-1:0]   a;
   logic [XLEN-1:0]   b;
   logic [4:0]        opc;
   logic [ROB_W-1:0]  rob;
   logic [DEST_W-1:0] dest;
   logic              valid_in;
   logic              wb_ready;
   logic              ready;
   logic [XLEN-1:0]   result;
   logic [ROB_W-1:0]  rob_out;
   logic [DEST_W-1:0] dest_out;
   logic              valid_out;
   logic              wb_valid;

   logic [63:0]       a64;
   logic [63:0]       b64;
   logic              valid64;
   logic              ready64;
   logic [63:0]       result64;
   logic [ROB_W-1:0]  rob64;
   logic [DEST_W-1:0] dest64;
   logic              valid64_out;
   logic              wb_valid64;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_pipe #(.XLEN(XLEN), .ROB_W(ROB_W), .DEST_W(DEST_W)) dut (
      .cpu_clock_i (clk),
      .cpu_reset_i (rst),
      .flush_i     (flush),
      .a_i         (a),
      .b_i         (b),
      .opc_i       (opc),
      .rob_id_i    (rob),
      .dest_i      (dest),
      .valid_i     (valid_in),
      .ready_o     (ready),
      .result_o    (result),
      .rob_id_o    (rob_out),
      .dest_o      (dest_out),
      .valid_o     (valid_out),
      .wb_valid_o  (wb_valid),
      .wb_ready_i  (wb_ready)
   );

   alu_pipe #(.XLEN(64), .ROB_W(ROB_W), .DEST_W(DEST_W)) dut64 (
      .cpu_clock_i (clk),
      .cpu_reset_i (rst),
      .flush_i     (flush),
      .a_i         (a64),
      .b_i         (b64),
      .opc_i       (opc),
      .rob_id_i    (rob),
      .dest_i      (dest),
      .valid_i     (valid64),
      .ready_o     (ready64),
      .result_o    (result64),
      .rob_id_o    (rob64),
      .dest_o      (dest64),
      .valid_o     (valid64_out),
      .wb_valid_o  (wb_valid64),
      .wb_ready_i  (wb_ready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: results straight from the opcode definitions.
   function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] x,
                                           input logic [31:0] y);
      int          sh;
      logic [31:0] r;
      sh = int'(y[4:0]);
      r  = 32'd0;
      if (op[4]) begin
`ifdef CALVERA_ALU_ZBB_EN
         case (op[2:0])
            3'd0: r = ($signed(x) < $signed(y)) ? x : y;
            3'd1: r = ($signed(x) > $signed(y)) ? x : y;
            3'd2: r = (x < y) ? x : y;
            3'd3: r = (x > y) ? x : y;
            3'd4: r = x & ~y;
            3'd5: r = x | ~y;
            3'd6: r = ~(x ^ y);
            default: begin
               int n;
               n = 0;
               while (n < 32 && x[31-n] == 1'b0) n++;
               r = n;
            end
         endcase
`else
         r = 32'd0;
`endif
      end else begin
         case (op[2:0])
            3'd0: r = op[3] ? (x - y) : (x + y);
            3'd1: r = x << sh;
            3'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: r = (x < y) ? 32'd1 : 32'd0;
            3'd4: r = x ^ y;
            3'd5: begin
               if (op[3]) r = $signed(x) >>> sh;
               else       r = x >> sh;
            end
            3'd6: r = x | y;
            default: r = x & y;
         endcase
      end
      return r;
   endfunction

   // One request into an empty pipe; reports edges until valid_o shows.
   task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] tag, input logic [5:0] dst,
                        output logic [31:0] res, output logic [4:0] tag_o,
                        output logic wbv, output int lat);
      @(negedge clk);
      opc = op; a = x; b = y; rob = tag; dest = dst;
      valid_in = 1'b1; wb_ready = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      valid_in = 1'b0;
      while (!valid_out && lat < 10) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      res = result; tag_o = rob_out; wbv = wb_valid;
   endtask

   typedef struct packed {
      logic [4:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      logic [5:0]  dst;
      logic [31:0] exp;
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  tag;
      logic [5:0]  dst;
      logic [31:0] t;
   } exp_t;

   vec_t vecs[$];
   exp_t q[$];

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] res;
      logic [4:0]  tag_o;
      logic        wbv;
      int          lat;
      logic [31:0] held_res;
      logic [4:0]  seen[$];
      logic        exp_ready;
      logic        exp_v;
      logic [31:0] pick [0:4];

      rst = 1'b1; flush = 1'b0; a = '0; b = '0; opc = '0; rob = '0; dest = '0;
      valid_in = 1'b0; wb_ready = 1'b0; a64 = '0; b64 = '0; valid64 = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset valid_o", valid_out, 1'b0);
      check("reset wb_valid_o", wb_valid, 1'b0);
      check("reset result_o", result, 32'h0);
      check("reset rob_id_o", rob_out, 5'h0);
      check("reset dest_o", dest_out, 6'h0);
      check("reset ready_o", ready, 1'b1);
      rst = 1'b0;

      // Vector table
      vecs.push_back('{5'b00000, 32'h7FFFFFFF, 32'h00000001, 6'd5, 32'h80000000});
      vecs.push_back('{5'b00000, 32'h7FFFFFFF, 32'h00000001, 6'd0, 32'h80000000});
      vecs.push_back('{5'b01101, 32'h80000000, 32'h00000024, 6'd1, 32'hF8000000});
      vecs.push_back('{5'b00101, 32'h80000000, 32'h00000024, 6'd2, 32'h08000000});
      vecs.push_back('{5'b00010, 32'hFFFFFFFF, 32'h00000001, 6'd3, 32'h00000001});
      vecs.push_back('{5'b00011, 32'hFFFFFFFF, 32'h00000001, 6'd4, 32'h00000000});
      vecs.push_back('{5'b01000, 32'h00000003, 32'h00000005, 6'd6, 32'hFFFFFFFE});
      vecs.push_back('{5'b00001, 32'h00000001, 32'h00000021, 6'd7, 32'h00000002});
      vecs.push_back('{5'b01001, 32'h00000003, 32'h00000004, 6'd8, 32'h00000030});
      vecs.push_back('{5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 6'd9, 32'h0FF00FF0});
      vecs.push_back('{5'b00110, 32'hF0F0F0F0, 32'hFF00FF00, 6'd9, 32'hFFF0FFF0});
      vecs.push_back('{5'b00111, 32'hF0F0F0F0, 32'hFF00FF00, 6'd9, 32'hF000F000});
`ifdef CALVERA_ALU_ZBB_EN
      vecs.push_back('{5'b10010, 32'hFFFFFFFF, 32'h00000001, 6'd10, 32'h00000001});
      vecs.push_back('{5'b10000, 32'hFFFFFFFF, 32'h00000001, 6'd10, 32'hFFFFFFFF});
      vecs.push_back('{5'b10001, 32'hFFFFFFFF, 32'h00000001, 6'd10, 32'h00000001});
      vecs.push_back('{5'b10011, 32'hFFFFFFFF, 32'h00000001, 6'd10, 32'hFFFFFFFF});
      vecs.push_back('{5'b10100, 32'hF0F0F0F0, 32'hFF00FF00, 6'd11, 32'h00F000F0});
      vecs.push_back('{5'b10101, 32'hF0F0F0F0, 32'hFF00FF00, 6'd11, 32'hF0FFF0FF});
      vecs.push_back('{5'b10110, 32'hF0F0F0F0, 32'hFF00FF00, 6'd11, 32'hF00FF00F});
      vecs.push_back('{5'b10111, 32'h00010000, 32'h00000000, 6'd12, 32'd15});
      vecs.push_back('{5'b10111, 32'h00000000, 32'h00000000, 6'd12, 32'd32});
`else
      vecs.push_back('{5'b10111, 32'h00010000, 32'h00000000, 6'd12, 32'h00000000});
      vecs.push_back('{5'b10000, 32'hFFFFFFFF, 32'h00000001, 6'd12, 32'h00000000});
`endif
      for (int i = 0; i < vecs.size(); i++) begin
         issue(vecs[i].op, vecs[i].x, vecs[i].y, 5'(i), vecs[i].dst, res, tag_o, wbv, lat);
         check($sformatf("vec%0d latency", i), lat, 2);
         check($sformatf("vec%0d result", i), res, vecs[i].exp);
         check($sformatf("vec%0d rob_id", i), tag_o, 5'(i));
         check($sformatf("vec%0d wb_valid", i), wbv, vecs[i].dst != 6'd0);
      end

      // XLEN=64 left shift by 63
      @(negedge clk);
      a64 = 64'd1; b64 = 64'd63; opc = 5'b00001; valid64 = 1'b1; wb_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid64 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("x64 sll valid", valid64_out, 1'b1);
      check("x64 sll result", result64, 64'h8000000000000000);

      // Back-pressure: tags 1,2,3 with writeback stalled three cycles
      @(negedge clk);
      opc = 5'b00000; a = 32'd10; b = 32'd1; dest = 6'd1; rob = 5'd1; valid_in = 1'b1; wb_ready = 1'b1;
      @(negedge clk);
      a = 32'd20; rob = 5'd2;
      @(negedge clk);
      check("stall first valid", valid_out, 1'b1);
      check("stall first tag", rob_out, 5'd1);
      held_res = result;
      a = 32'd30; rob = 5'd3; wb_ready = 1'b0;
      #1;
      check("stall ready drop", ready, 1'b0);
      repeat (2) begin
         @(negedge clk);
         check("stall ready held", ready, 1'b0);
         check("stall tag held", rob_out, 5'd1);
         check("stall result held", result, held_res);
         check("stall valid held", valid_out, 1'b1);
      end
      @(negedge clk);
      wb_ready = 1'b1;
      seen.delete();
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) valid_in = 1'b0;
         #1;
         if (valid_out) seen.push_back(rob_out);
      end
      check("stall drain count", seen.size(), 3);
      for (int k = 0; k < 3 && k < seen.size(); k++) begin
         check($sformatf("stall order %0d", k), seen[k], 5'(k + 1));
      end

      // Flush with S1, output and a new request all live
      @(negedge clk);
      opc = 5'b00000; a = 32'd5; b = 32'd6; dest = 6'd2; rob = 5'd4; valid_in = 1'b1; wb_ready = 1'b1;
      @(negedge clk);
      rob = 5'd5;
      @(negedge clk);
      check("flush pre valid", valid_out, 1'b1);
      check("flush pre tag", rob_out, 5'd4);
      rob = 5'd6; flush = 1'b1;
      #1;
      check("flush ready", ready, 1'b1);
      @(negedge clk);
      flush = 1'b0; valid_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("flush quiet %0d", k), valid_out, 1'b0);
         @(negedge clk);
      end

      // Reset in the middle of a stall
      opc = 5'b00000; a = 32'd1; b = 32'd1; dest = 6'd3; rob = 5'd7; valid_in = 1'b1; wb_ready = 1'b1;
      @(negedge clk);
      rob = 5'd8;
      @(negedge clk);
      valid_in = 1'b0; wb_ready = 1'b0;
      @(negedge clk);
      check("rststall pre valid", valid_out, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rststall valid_o", valid_out, 1'b0);
      check("rststall wb_valid_o", wb_valid, 1'b0);
      check("rststall result_o", result, 32'h0);
      check("rststall rob_id_o", rob_out, 5'h0);
      check("rststall dest_o", dest_out, 6'h0);
      check("rststall ready_o", ready, 1'b1);
      wb_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("rststall quiet %0d", k), valid_out, 1'b0);
      end

      // Randomized run against the queue model
      pick[0] = 32'h0; pick[1] = 32'hFFFFFFFF; pick[2] = 32'h80000000;
      pick[3] = 32'h7FFFFFFF; pick[4] = 32'h1;
      q.delete();
      for (int cyc = 0; cyc < 2012; cyc++) begin
         @(negedge clk);
         if (cyc < 2000) begin
            valid_in = ($urandom_range(0, 3) != 0);
            wb_ready = ($urandom_range(0, 3) != 0);
            a    = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
            b    = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
            opc  = 5'($urandom_range(0, 23));
            rob  = 5'($urandom);
            dest = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom);
         end else begin
            valid_in = 1'b0;
            wb_ready = 1'b1;
         end
         #1;
         exp_ready = !(q.size() == 2 && !wb_ready);
         check("rnd ready_o", ready, exp_ready);
         exp_v = (q.size() > 0) && (q[0].t <= 32'(cyc));
         check("rnd valid_o", valid_out, exp_v);
         if (exp_v && valid_out) begin
            check("rnd result", result, q[0].res);
            check("rnd rob_id", rob_out, q[0].tag);
            check("rnd dest", dest_out, q[0].dst);
            check("rnd wb_valid", wb_valid, q[0].dst != 6'd0);
            if (wb_ready) begin
               void'(q.pop_front());
               if (q.size() > 0 && q[0].t < 32'(cyc + 1)) q[0].t = 32'(cyc + 1);
            end
         end
         if (valid_in && ready) begin
            q.push_back('{ref_alu(opc, a, b), rob, dest, 32'(cyc + 2)});
         end
      end
      check("rnd all drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
